// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single pipelined memory port. Read return data is
// steered back to its master through an in-order tag FIFO of master IDs.
module mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          FIXED_PRIORITY  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_byte_enable,
    input  logic        m0_write_req,
    input  logic        m0_read_req,
    output logic [31:0] m0_read_data,
    output logic        m0_read_data_valid,

    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_byte_enable,
    input  logic        m1_write_req,
    input  logic        m1_read_req,
    output logic [31:0] m1_read_data,
    output logic        m1_read_data_valid,

    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write_req,
    output logic        mem_read_req,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_data_valid,

    output logic        protocol_error
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    master_t          tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    master_t          rr_last;

    master_t grant;
    master_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    elig0;
    logic    elig1;
    logic    grant_valid;
    logic    sel_write;
    logic    sel_read;
    logic    accept;
    logic    push;
    logic    pop;

    always_comb begin
        fifo_full  = (count == (PTR_W+1)'(MAX_OUTSTANDING));
        fifo_empty = (count == '0);
        elig0      = m0_write_req | (m0_read_req & ~fifo_full);
        elig1      = m1_write_req | (m1_read_req & ~fifo_full);
        grant_valid = elig0 | elig1;

        grant = M0;
        if (elig0 && elig1)
            grant = FIXED_PRIORITY ? M0 : ((rr_last == M0) ? M1 : M0);
        else if (elig1)
            grant = M1;

        sel_write = (grant == M1) ? m1_write_req : m0_write_req;
        sel_read  = (grant == M1) ? m1_read_req  : m0_read_req;

        mem_addr        = (grant == M1) ? m1_addr        : m0_addr;
        mem_write_data  = (grant == M1) ? m1_write_data  : m0_write_data;
        mem_byte_enable = (grant == M1) ? m1_byte_enable : m0_byte_enable;

        // A master asserting both requests is serviced as a write
        mem_write_req = ~reset & grant_valid & sel_write;
        mem_read_req  = ~reset & grant_valid & ~sel_write & sel_read;

        m0_ready = ~reset & mem_ready & grant_valid & (grant == M0);
        m1_ready = ~reset & mem_ready & grant_valid & (grant == M1);

        accept = mem_ready & (mem_read_req | mem_write_req);
        push   = accept & mem_read_req;
        pop    = ~reset & mem_read_data_valid & ~fifo_empty;
        head   = tag_mem[rd_ptr];

        m0_read_data       = mem_read_data;
        m1_read_data       = mem_read_data;
        m0_read_data_valid = pop & (head == M0);
        m1_read_data_valid = pop & (head == M1);
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rr_last        <= M1;
            protocol_error <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept)
                rr_last <= grant;
            protocol_error <= protocol_error
                            | (mem_read_data_valid & fifo_empty)
                            | (m0_read_req & m0_write_req)
                            | (m1_read_req & m1_write_req);
        end
    end

endmodule
